// File: rtl/fp_rgb2grey_stream_ctrl_if.sv
// Handshake bundle between a host/stream source and the RGB-to-grey
// streaming controller, including the side channel to the combinational
// datapath and the frame status outputs.
interface fp_rgb2grey_stream_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   // frame control
   logic             start;
   logic [CNT_W-1:0] frame_len;
   // upstream pixel stream
   logic             in_valid;
   logic             in_ready;
   logic [47:0]      in_rgb;
   // datapath side channel
   logic [47:0]      dp_rgb;
   logic [15:0]      dp_grey;
   // downstream grey stream
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_grey;
   logic             out_last;
   // status
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] range_err_cnt;

   // host / stream environment side
   modport master (
      output start, frame_len, in_valid, in_rgb, dp_grey, out_ready,
      input  in_ready, dp_rgb, out_valid, out_grey, out_last,
             busy, done, range_err_cnt
   );

   // controller side
   modport slave (
      input  start, frame_len, in_valid, in_rgb, dp_grey, out_ready,
      output in_ready, dp_rgb, out_valid, out_grey, out_last,
             busy, done, range_err_cnt
   );
endinterface

// File: rtl/fp_rgb2grey_stream_ctrl.sv
// Frame-level streaming controller for the FP16 RGB-to-grey datapath.
// Pixels are registered onto the datapath input (S1); the combinational
// grey result is captured into an output register (S2) and presented
// downstream with an end-of-frame marker. Out-of-range inputs are counted.
module fp_rgb2grey_stream_ctrl #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned EXP_MAX = 22
) (
   input  logic                           clk,
   input  logic                           rst,
   fp_rgb2grey_stream_ctrl_if.slave       bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] acc_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic             done_q;

   // S1: datapath input register
   logic             s1_v;
   logic [47:0]      s1_rgb;
   logic             s1_last;

   // S2: output register
   logic             out_valid_q;
   logic [15:0]      out_grey_q;
   logic             out_last_q;

   // handshake decode
   logic             s2_free;
   logic             s1_adv;
   logic             in_ready_c;
   logic             accept;
   logic             last_acc;
   logic             out_hs;
   logic             pix_err;

   // True when an FP16 channel is negative or beyond the legal exponent range.
   function automatic logic chan_bad(input logic [15:0] h);
      return h[15] || (h[14:10] > 5'(EXP_MAX));
   endfunction

   // Flow-control decode; in_ready depends only on registered state and out_ready.
   always_comb begin
      s2_free    = !out_valid_q || bus.out_ready;
      s1_adv     = s1_v && s2_free;
      in_ready_c = (state == RUN) && (acc_cnt < len_q) && (!s1_v || s1_adv);
      accept     = bus.in_valid && in_ready_c;
      last_acc   = (acc_cnt == len_q - CNT_W'(1));
      out_hs     = out_valid_q && bus.out_ready;
      pix_err    = chan_bad(bus.in_rgb[47:32]) ||
                   chan_bad(bus.in_rgb[31:16]) ||
                   chan_bad(bus.in_rgb[15:0]);
   end

   // Frame FSM: length latch, pixel/error counters and done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         len_q   <= '0;
         acc_cnt <= '0;
         err_cnt <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.frame_len != '0) begin
                     state   <= RUN;
                     len_q   <= bus.frame_len;
                     acc_cnt <= '0;
                     err_cnt <= '0;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (accept) begin
                  acc_cnt <= acc_cnt + CNT_W'(1);
                  if (pix_err && (err_cnt != '1)) begin
                     err_cnt <= err_cnt + CNT_W'(1);
                  end
                  if (last_acc) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (out_hs && out_last_q) begin
                  state  <= IDLE;
                  done_q <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // S1 register: an accept refills the stage in the same cycle it advances.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v    <= 1'b0;
         s1_rgb  <= '0;
         s1_last <= 1'b0;
      end else if (accept) begin
         s1_v    <= 1'b1;
         s1_rgb  <= bus.in_rgb;
         s1_last <= last_acc;
      end else if (s1_adv) begin
         s1_v    <= 1'b0;
      end
   end

   // S2 register: capture the datapath result, hold it while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_grey_q  <= '0;
         out_last_q  <= 1'b0;
      end else if (s1_adv) begin
         out_valid_q <= 1'b1;
         out_grey_q  <= bus.dp_grey;
         out_last_q  <= s1_last;
      end else if (out_hs) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.dp_rgb        = s1_v ? s1_rgb : '0;
   assign bus.in_ready      = in_ready_c;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_grey      = out_grey_q;
   assign bus.out_last      = out_last_q;
   assign bus.busy          = (state != IDLE);
   assign bus.done          = done_q;
   assign bus.range_err_cnt = err_cnt;

endmodule

// File: tb/tb_fp_rgb2grey_stream_ctrl.sv
// Self-checking bench for the RGB-to-grey streaming controller. The datapath
// is stubbed as grey = R channel so ordering is directly observable.
module tb_fp_rgb2grey_stream_ctrl;

   localparam int unsigned CNT_W = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   fp_rgb2grey_stream_ctrl_if #(.CNT_W(CNT_W)) bus ();

   fp_rgb2grey_stream_ctrl #(
      .CNT_W   (CNT_W),
      .EXP_MAX (22)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.dp_grey = bus.dp_rgb[47:32];

   int errors = 0;
   int checks = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic chan_bad(input logic [15:0] h);
      return h[15] || (h[14:10] > 5'd22);
   endfunction

   // scoreboard: {last, grey}
   logic [16:0]      sb[$];
   int               done_cnt = 0;
   int               out_cnt  = 0;
   logic [CNT_W-1:0] m_len    = '0;
   logic [CNT_W-1:0] m_acc    = '0;
   logic [CNT_W-1:0] m_err    = '0;
   logic             bp_en    = 1'b0;

   // out_ready driver: always ready, or the 1,0,0,1 backpressure pattern
   initial begin
      logic [3:0] pat;
      int unsigned idx;
      pat = 4'b1001;
      idx = 0;
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bp_en) begin
            bus.out_ready = pat[3 - (idx % 4)];
            idx++;
         end else begin
            bus.out_ready = 1'b1;
         end
      end
   end

   // monitor: push on accept, pop on output handshake, check stall hold
   initial begin
      logic [16:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            sb.delete();
            m_err = '0;
            m_acc = '0;
         end else begin
            if (bus.done) begin
               done_cnt++;
               check_eq("err_at_done", 64'(bus.range_err_cnt), 64'(m_err));
            end
            if (bus.out_valid) begin
               if (sb.size() == 0) begin
                  check_eq("sb_has_entry", 64'(sb.size()), 64'd1);
               end else if (bus.out_ready) begin
                  e = sb.pop_front();
                  check_eq("out_grey", 64'(bus.out_grey), 64'(e[15:0]));
                  check_eq("out_last", 64'(bus.out_last), 64'(e[16]));
                  out_cnt++;
               end else begin
                  check_eq("hold_grey", 64'(bus.out_grey), 64'(sb[0][15:0]));
                  check_eq("hold_last", 64'(bus.out_last), 64'(sb[0][16]));
               end
            end
            if (!bus.busy && bus.start && (bus.frame_len != '0)) begin
               m_len = bus.frame_len;
               m_acc = '0;
               m_err = '0;
            end
            if (bus.in_valid && bus.in_ready) begin
               sb.push_back({(m_acc == m_len - CNT_W'(1)), bus.in_rgb[47:32]});
               if (chan_bad(bus.in_rgb[47:32]) || chan_bad(bus.in_rgb[31:16]) ||
                   chan_bad(bus.in_rgb[15:0]))
                  m_err = m_err + CNT_W'(1);
               m_acc = m_acc + CNT_W'(1);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input int n);
      bus.start     = 1'b1;
      bus.frame_len = CNT_W'(n);
      tick();
      bus.start     = 1'b0;
   endtask

   // present one pixel and hold it until accepted; in_valid is left high
   task automatic send(input logic [47:0] px);
      bit ok;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_rgb   = px;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_eq("in_ready_timeout", 64'(ok), 64'd1);
      tick();
   endtask

   task automatic wait_done(input string tag);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (done_cnt != d0) break;
      end
      check_eq(tag, 64'(done_cnt - d0), 64'd1);
   endtask

   initial begin
      int d0;
      int o0;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.frame_len = '0;
      bus.in_valid  = 1'b0;
      bus.in_rgb    = '0;
      repeat (3) tick();
      @(negedge clk);
      check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst_out_grey",  64'(bus.out_grey),  64'd0);
      check_eq("rst_out_last",  64'(bus.out_last),  64'd0);
      check_eq("rst_busy",      64'(bus.busy),      64'd0);
      check_eq("rst_done",      64'(bus.done),      64'd0);
      check_eq("rst_in_ready",  64'(bus.in_ready),  64'd0);
      check_eq("rst_dp_rgb",    64'(bus.dp_rgb),    64'd0);
      check_eq("rst_err_cnt",   64'(bus.range_err_cnt), 64'd0);
      tick();
      rst = 1'b0;
      tick();

      // single pixel, latency and done timing
      start_frame(1);
      bus.in_valid = 1'b1;
      bus.in_rgb   = 48'h5BF8_3C00_0000;
      @(negedge clk);
      check_eq("s1_in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      check_eq("s1_lat1_valid", 64'(bus.out_valid), 64'd0);
      check_eq("s1_dp_rgb", 64'(bus.dp_rgb), 64'h5BF8_3C00_0000);
      @(negedge clk);
      check_eq("s1_lat2_valid", 64'(bus.out_valid), 64'd1);
      check_eq("s1_grey", 64'(bus.out_grey), 64'h5BF8);
      check_eq("s1_last", 64'(bus.out_last), 64'd1);
      check_eq("s1_busy", 64'(bus.busy), 64'd1);
      @(negedge clk);
      check_eq("s1_done", 64'(bus.done), 64'd1);
      check_eq("s1_busy_end", 64'(bus.busy), 64'd0);
      check_eq("s1_valid_end", 64'(bus.out_valid), 64'd0);
      tick();

      // streaming with backpressure
      o0 = out_cnt;
      bp_en = 1'b1;
      start_frame(8);
      for (int i = 0; i < 8; i++) send({16'(16'h3C00 + i), 32'h3C00_3C00});
      bus.in_valid = 1'b0;
      wait_done("done_stream");
      bp_en = 1'b0;
      check_eq("stream_count", 64'(out_cnt - o0), 64'd8);
      check_eq("stream_sb_empty", 64'(sb.size()), 64'd0);
      tick();

      // range errors, including exponent 22 as the legal boundary
      start_frame(4);
      send(48'hBC00_3C00_3C00);
      send(48'h3C01_5C00_3C00);
      send(48'h3C02_3C00_3C00);
      send(48'h3C03_5BFF_3C00);
      bus.in_valid = 1'b0;
      wait_done("done_range");
      check_eq("range_err_cnt", 64'(bus.range_err_cnt), 64'd2);
      tick();

      // reset mid-frame
      d0 = done_cnt;
      start_frame(10);
      for (int i = 0; i < 5; i++) send({16'(16'h4000 + i), 32'h3C00_3C00});
      bus.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      check_eq("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      check_eq("mid_rst_busy", 64'(bus.busy), 64'd0);
      check_eq("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
      rst = 1'b0;
      repeat (3) tick();
      check_eq("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
      o0 = out_cnt;
      start_frame(2);
      send(48'h4400_3C00_3C00);
      send(48'h4401_3C00_3C00);
      bus.in_valid = 1'b0;
      wait_done("done_after_rst");
      check_eq("after_rst_count", 64'(out_cnt - o0), 64'd2);
      tick();

      // start while busy is ignored
      o0 = out_cnt;
      start_frame(3);
      send(48'h4800_3C00_3C00);
      bus.in_valid  = 1'b0;
      bus.start     = 1'b1;
      bus.frame_len = CNT_W'(5);
      tick();
      bus.start     = 1'b0;
      send(48'h4801_3C00_3C00);
      send(48'h4802_3C00_3C00);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check_eq("busy_start_len", 64'(bus.in_ready), 64'd0);
      wait_done("done_busy_start");
      check_eq("busy_start_count", 64'(out_cnt - o0), 64'd3);
      tick();

      // zero-length frame
      start_frame(0);
      @(negedge clk);
      check_eq("zero_done", 64'(bus.done), 64'd1);
      check_eq("zero_in_ready", 64'(bus.in_ready), 64'd0);
      check_eq("zero_busy", 64'(bus.busy), 64'd0);
      tick();
      @(negedge clk);
      check_eq("zero_done_once", 64'(bus.done), 64'd0);
      check_eq("zero_in_ready2", 64'(bus.in_ready), 64'd0);
      tick();

      check_eq("final_sb_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
